// File: rtl/cim_acc_scheduler_if.sv
// cim_acc_scheduler_if: PE request handshake plus memory/CIM control bus of the accumulation scheduler
interface cim_acc_scheduler_if #(parameter int ADDR_W = 8);
    logic [1:0]        req_valid_i;
    logic [ADDR_W-1:0] req_addr_i_1;
    logic [ADDR_W-1:0] req_addr_i_2;
    logic [1:0]        req_first_i;
    logic [1:0]        req_ready_o;
    logic              mem_rd_en_o;
    logic              mem_wr_en_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_wr_src_o;
    logic              lane_sel_o;
    logic              cim_valid_o;
    modport master (
        output req_valid_i, req_addr_i_1, req_addr_i_2, req_first_i,
        input  req_ready_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_src_o, lane_sel_o, cim_valid_o
    );
    modport slave (
        input  req_valid_i, req_addr_i_1, req_addr_i_2, req_first_i,
        output req_ready_o, mem_rd_en_o, mem_wr_en_o, mem_addr_o, mem_wr_src_o, lane_sel_o, cim_valid_o
    );
endinterface

// File: rtl/cim_acc_scheduler.sv
// cim_acc_scheduler: read-modify-write sequencer and round-robin arbiter for the shared CIM output memory
// Defining CIM_SCHED_STATS_EN adds saturating per-lane completion counters op_cnt_1_o/op_cnt_2_o.
module cim_acc_scheduler #(
    parameter int ADDR_W  = 8,
    parameter int MEM_LAT = 1,
    parameter int CIM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    cim_acc_scheduler_if.slave bus,
    input  logic [1:0]         scan_mode,
    output logic               scan_grant_o,
    output logic               busy_o
`ifdef CIM_SCHED_STATS_EN
    ,
    output logic [15:0]        op_cnt_1_o,
    output logic [15:0]        op_cnt_2_o
`endif
);
    localparam int CNT_W = $clog2((MEM_LAT > CIM_LAT ? MEM_LAT : CIM_LAT) + 1);

    typedef enum logic [2:0] {IDLE, RD, WAIT, ACC, WR, SCAN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
    logic              first_q, first_d, lane_q, lane_d, last_q, last_d;
    logic              rd_q, rd_d, wr_q, wr_d, src_q, src_d, sel_q, sel_d;
    logic              cimv_q, cimv_d, scan_q, scan_d, busy_q, busy_d;
    logic [1:0]        ready_q, ready_d;
    logic              pick, op;

    // Lane 2 wins when it is alone or when lane 1 had the previous grant.
    assign pick = bus.req_valid_i[1] && (!bus.req_valid_i[0] || !last_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        first_d = first_q;
        lane_d  = lane_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (scan_mode != 2'b00) begin
                    state_d = SCAN;
                end else if (|bus.req_valid_i) begin
                    lane_d  = pick;
                    last_d  = pick;
                    addr_d  = pick ? bus.req_addr_i_2 : bus.req_addr_i_1;
                    first_d = bus.req_first_i[pick];
                    state_d = first_d ? WR : RD;
                end
            end
            RD: begin
                state_d = WAIT;
                cnt_d   = CNT_W'(MEM_LAT - 1);
            end
            WAIT: begin
                state_d = (cnt_q == '0) ? ACC : WAIT;
                cnt_d   = (cnt_q == '0) ? CNT_W'(CIM_LAT - 1) : cnt_q - 1'b1;
            end
            ACC: begin
                state_d = (cnt_q == '0) ? WR : ACC;
                cnt_d   = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
            end
            WR:      state_d = IDLE;
            SCAN:    state_d = (scan_mode == 2'b00) ? IDLE : SCAN;
            default: state_d = IDLE;
        endcase
        // Outputs are registered from the next state so they line up with the state they describe.
        op         = state_d inside {RD, WAIT, ACC, WR};
        rd_d       = state_d == RD;
        wr_d       = state_d == WR;
        cimv_d     = state_d == ACC;
        scan_d     = state_d == SCAN;
        busy_d     = state_d != IDLE;
        src_d      = wr_d & first_d;
        sel_d      = op & lane_d;
        mem_addr_d = op ? addr_d : '0;
        ready_d    = wr_d ? (lane_d ? 2'b10 : 2'b01) : 2'b00;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            first_q    <= 1'b0;
            lane_q     <= 1'b0;
            last_q     <= 1'b1;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            src_q      <= 1'b0;
            sel_q      <= 1'b0;
            cimv_q     <= 1'b0;
            scan_q     <= 1'b0;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
            ready_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            first_q    <= first_d;
            lane_q     <= lane_d;
            last_q     <= last_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            src_q      <= src_d;
            sel_q      <= sel_d;
            cimv_q     <= cimv_d;
            scan_q     <= scan_d;
            busy_q     <= busy_d;
            mem_addr_q <= mem_addr_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.mem_rd_en_o  = rd_q;
    assign bus.mem_wr_en_o  = wr_q;
    assign bus.mem_wr_src_o = src_q;
    assign bus.lane_sel_o   = sel_q;
    assign bus.cim_valid_o  = cimv_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.req_ready_o  = ready_q;
    assign scan_grant_o     = scan_q;
    assign busy_o           = busy_q;

`ifdef CIM_SCHED_STATS_EN
    logic [15:0] op_cnt_1_q, op_cnt_1_d, op_cnt_2_q, op_cnt_2_d;

    always_comb begin
        op_cnt_1_d = (ready_q[0] && op_cnt_1_q != 16'hFFFF) ? op_cnt_1_q + 16'd1 : op_cnt_1_q;
        op_cnt_2_d = (ready_q[1] && op_cnt_2_q != 16'hFFFF) ? op_cnt_2_q + 16'd1 : op_cnt_2_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_cnt_1_q <= 16'd0;
            op_cnt_2_q <= 16'd0;
        end else begin
            op_cnt_1_q <= op_cnt_1_d;
            op_cnt_2_q <= op_cnt_2_d;
        end
    end

    assign op_cnt_1_o = op_cnt_1_q;
    assign op_cnt_2_o = op_cnt_2_q;
`endif
endmodule
